// File: rtl/uart_pkg.sv
// Shared widths and limits for the UART receive path, plus the prescale
// normalisation used wherever the oversampling ratio is consumed.
package uart_pkg;

  localparam int PRESCALE_W = 5;
  localparam int BIT_CNT_W  = 4;

  localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = 5'd8;
  localparam logic [BIT_CNT_W-1:0]  BIT_CNT_MAX  = 4'd15;

  // Odd ratios are rounded down to even, anything below the minimum is clamped up.
  function automatic logic [PRESCALE_W-1:0] eff_prescale(input logic [PRESCALE_W-1:0] raw);
    logic [PRESCALE_W-1:0] even;
    even = {raw[PRESCALE_W-1:1], 1'b0};
    return (even < MIN_PRESCALE) ? MIN_PRESCALE : even;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input; the whole
// chain loads rst_val on reset so the output is defined from the first cycle.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic rst_val,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{rst_val}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front-end: line synchroniser, edge/bit pacing counters and a
// 3-sample mid-bit majority vote for the receive FSM.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  counter_enable,
  input  logic                  data_sample_en,
  output logic                  rx_sync,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  prescale_err
);

  logic [PRESCALE_W-1:0] p_eff;
  logic [PRESCALE_W-1:0] p_last;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] half_m1;
  logic [PRESCALE_W-1:0] half_p1;
  logic                  at_s0;
  logic                  at_s1;
  logic                  at_s2;
  logic                  s0;
  logic                  s1;
  logic                  got_s0;
  logic                  got_s1;
  logic                  vote;

  assign prescale_err = (Prescale < MIN_PRESCALE) || Prescale[0];

  assign p_eff   = eff_prescale(Prescale);
  assign p_last  = p_eff - 5'd1;
  assign half    = {1'b0, p_eff[PRESCALE_W-1:1]};
  assign half_m1 = half - 5'd1;
  assign half_p1 = half + 5'd1;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .d       (RX_IN),
    .rst_val (1'b1),
    .q       (rx_sync)
  );

  // A shrinking prescale can leave edge_count beyond the new wrap point, hence >=.
  always_ff @(posedge clk) begin
    if (rst || !counter_enable) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (edge_count >= p_last) begin
      edge_count <= '0;
      if (bit_count != BIT_CNT_MAX) begin
        bit_count <= bit_count + 4'd1;
      end
    end else begin
      edge_count <= edge_count + 5'd1;
    end
  end

  assign at_s0 = data_sample_en && (edge_count == half_m1);
  assign at_s1 = data_sample_en && (edge_count == half);
  assign at_s2 = data_sample_en && (edge_count == half_p1);

  // The third sample feeds the vote directly, so the result is visible at P/2+2.
  assign vote = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);

  // got_s0/got_s1 require the three captures on consecutive enabled cycles,
  // so any drop of data_sample_en discards a partial bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0           <= 1'b1;
      s1           <= 1'b1;
      got_s0       <= 1'b0;
      got_s1       <= 1'b0;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      got_s0       <= at_s0;
      got_s1       <= at_s1 && got_s0;
      sample_valid <= at_s2 && got_s1;
      if (at_s0) begin
        s0 <= rx_sync;
      end
      if (at_s1) begin
        s1 <= rx_sync;
      end
      if (at_s2 && got_s1) begin
        sampled_bit <= vote;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: directed frames plus random traffic, checked every
// cycle against a history-window model of the sampler's rules.
module tb_uart_rx_sampler;

  localparam int S = 2;

  logic       clk;
  logic       rst;
  logic       RX_IN;
  logic [4:0] Prescale;
  logic       counter_enable;
  logic       data_sample_en;
  logic       rx_sync;
  logic [4:0] edge_count;
  logic [3:0] bit_count;
  logic       sampled_bit;
  logic       sample_valid;
  logic       prescale_err;

  int checks;
  int failures;

  uart_rx_sampler #(
    .SYNC_STAGES (S)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .RX_IN          (RX_IN),
    .Prescale       (Prescale),
    .counter_enable (counter_enable),
    .data_sample_en (data_sample_en),
    .rx_sync        (rx_sync),
    .edge_count     (edge_count),
    .bit_count      (bit_count),
    .sampled_bit    (sampled_bit),
    .sample_valid   (sample_valid),
    .prescale_err   (prescale_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_p(input int raw);
    int e;
    e = raw - (raw % 2);
    if (e < 8) e = 8;
    return e;
  endfunction

  // ---------------- reference model ----------------
  int m_known;
  int m_rx, m_edge, m_bit, m_sbit, m_valid;
  int rx_q[$];
  int hen[2], hedge[2], hrx[2], hp[2];
  int dut_votes[$];
  int mdl_votes[$];

  initial m_known = 0;

  always @(negedge clk) begin
    int p, h0, h1, h2, nv, ne, nb;
    if (m_known != 0) begin
      chk("rx_sync",      int'(rx_sync),      m_rx);
      chk("edge_count",   int'(edge_count),   m_edge);
      chk("bit_count",    int'(bit_count),    m_bit);
      chk("sampled_bit",  int'(sampled_bit),  m_sbit);
      chk("sample_valid", int'(sample_valid), m_valid);
      chk("prescale_err", int'(prescale_err),
          ((int'(Prescale) < 8) || (Prescale[0] == 1'b1)) ? 1 : 0);
      if (sample_valid) dut_votes.push_back(int'(sampled_bit));
      if (m_valid != 0) mdl_votes.push_back(m_sbit);
    end
    p = eff_p(int'(Prescale));
    if (rst) begin
      m_known = 1;
      rx_q.delete();
      for (int i = 0; i < S - 1; i++) rx_q.push_back(1);
      m_rx = 1; m_edge = 0; m_bit = 0; m_sbit = 1; m_valid = 0;
      for (int i = 0; i < 2; i++) begin
        hen[i] = 0; hedge[i] = 0; hrx[i] = 1; hp[i] = 8;
      end
    end else if (m_known != 0) begin
      // A vote lands when the three previous cycles sat at P/2-1, P/2, P/2+1
      // with sampling enabled throughout.
      h0 = p / 2;
      h1 = hp[0] / 2;
      h2 = hp[1] / 2;
      nv = (data_sample_en && m_edge == h0 + 1 &&
            hen[0] != 0 && hedge[0] == h1 &&
            hen[1] != 0 && hedge[1] == h2 - 1) ? 1 : 0;
      if (counter_enable) begin
        if (m_edge >= p - 1) begin
          ne = 0;
          nb = (m_bit < 15) ? m_bit + 1 : 15;
        end else begin
          ne = m_edge + 1;
          nb = m_bit;
        end
      end else begin
        ne = 0;
        nb = 0;
      end
      if (nv != 0) m_sbit = ((m_rx + hrx[0] + hrx[1]) >= 2) ? 1 : 0;
      m_valid = nv;
      hen[1] = hen[0]; hedge[1] = hedge[0]; hrx[1] = hrx[0]; hp[1] = hp[0];
      hen[0] = data_sample_en ? 1 : 0; hedge[0] = m_edge; hrx[0] = m_rx; hp[0] = p;
      m_edge = ne;
      m_bit  = nb;
      rx_q.push_back(int'(RX_IN));
      m_rx = rx_q.pop_front();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    counter_enable = 1'b0;
    data_sample_en = 1'b0;
    RX_IN = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // Drives a frame with the counters started when the start bit reaches rx_sync.
  task automatic run_frame(input logic [9:0] bits, input int nbits, input int p,
                           input int g_bit, input int g_from, input int g_to,
                           input int rst_at, output int maxbit);
    int total, bi, pos;
    Prescale = 5'(p);
    dut_votes.delete();
    mdl_votes.delete();
    maxbit = 0;
    total = S + nbits * p + 2;
    for (int c = 0; c < total; c++) begin
      bi  = c / p;
      pos = c % p;
      RX_IN = (bi < nbits) ? bits[bi] : 1'b1;
      if (bi == g_bit && pos >= g_from && pos <= g_to) RX_IN = 1'b0;
      counter_enable = (c >= S);
      data_sample_en = (c >= S);
      rst = (c == rst_at);
      @(negedge clk);
      if (int'(bit_count) > maxbit) maxbit = int'(bit_count);
      if (c == rst_at + 1) begin
        chk("rst_mid_rx_sync",     int'(rx_sync),      1);
        chk("rst_mid_edge",        int'(edge_count),   0);
        chk("rst_mid_bit",         int'(bit_count),    0);
        chk("rst_mid_sampled_bit", int'(sampled_bit),  1);
        chk("rst_mid_valid",       int'(sample_valid), 0);
      end
      next_cycle();
    end
    idle(4);
  endtask

  task automatic count_test(input int raw, input int per, input int ncyc, input string tag);
    Prescale = 5'(raw);
    counter_enable = 1'b1;
    data_sample_en = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      chk({tag, "_err"}, int'(prescale_err), (raw < 8 || (raw % 2) == 1) ? 1 : 0);
      chk({tag, "_edge"}, int'(edge_count), k % per);
      chk({tag, "_bit"}, int'(bit_count), (k / per > 15) ? 15 : k / per);
      next_cycle();
    end
    idle(3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int maxbit;
    int exp_a5[9];
    logic [9:0] fb;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    RX_IN = 1'b1;
    Prescale = 5'd8;
    counter_enable = 1'b0;
    data_sample_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_rx_sync", int'(rx_sync), 1);
      chk("idle_edge",    int'(edge_count), 0);
      chk("idle_bit",     int'(bit_count), 0);
      chk("idle_valid",   int'(sample_valid), 0);
      next_cycle();
    end

    // 0xA5 at P=8: start bit then data LSB first.
    exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1};
    fb = {1'b1, 8'hA5, 1'b0};
    run_frame(fb, 9, 8, -1, 0, 0, -1, maxbit);
    chk("a5_maxbit", maxbit, 9);
    chk("a5_dut_votes", dut_votes.size(), 9);
    chk("a5_mdl_votes", mdl_votes.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < dut_votes.size()) chk("a5_dut_bit", dut_votes[i], exp_a5[i]);
      if (i < mdl_votes.size()) chk("a5_mdl_bit", mdl_votes[i], exp_a5[i]);
    end

    // Glitch inside the first (high) data bit at P=16.
    fb = 10'b1111111110;
    run_frame(fb, 3, 16, 1, 8, 8, -1, maxbit);
    chk("glitch1_count", dut_votes.size(), 3);
    if (dut_votes.size() > 1) chk("glitch1_dut", dut_votes[1], 1);
    if (mdl_votes.size() > 1) chk("glitch1_mdl", mdl_votes[1], 1);
    run_frame(fb, 3, 16, 1, 7, 8, -1, maxbit);
    chk("glitch2_count", dut_votes.size(), 3);
    if (dut_votes.size() > 1) chk("glitch2_dut", dut_votes[1], 0);
    if (mdl_votes.size() > 1) chk("glitch2_mdl", mdl_votes[1], 0);

    count_test(5, 8, 27, "p5");
    count_test(17, 16, 51, "p17");
    count_test(8, 8, 20 * 8, "sat");

    // Abort: counter_enable drops in the cycle where edge_count=7, bit_count=3.
    Prescale = 5'd8;
    RX_IN = 1'b1;
    data_sample_en = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      counter_enable = (k < 31);
      @(negedge clk);
      if (k == 31) begin
        chk("abort_pre_edge", int'(edge_count), 7);
        chk("abort_pre_bit",  int'(bit_count), 3);
      end
      if (k == 32) begin
        chk("abort_edge",  int'(edge_count), 0);
        chk("abort_bit",   int'(bit_count), 0);
        chk("abort_valid", int'(sample_valid), 0);
      end
      next_cycle();
    end
    idle(4);

    // Reset during bit 4 of an all-zero frame (sampled_bit is 0 beforehand).
    fb = {1'b1, 8'h00, 1'b0};
    run_frame(fb, 9, 8, -1, 0, 0, S + 4 * 8 + 3, maxbit);

    // Random traffic, including illegal and mid-frame prescale changes.
    Prescale = 5'(2 * $urandom_range(4, 15));
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) Prescale = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) RX_IN = ~RX_IN;
      if (counter_enable) begin
        if ($urandom_range(0, 299) == 0) counter_enable = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        counter_enable = 1'b1;
      end
      data_sample_en = ($urandom_range(0, 39) == 0) ? ~counter_enable : counter_enable;
      rst = ($urandom_range(0, 999) == 0);
      next_cycle();
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
